// File: rtl/enable_ctrl_pkg.sv
// Shared types and width helpers for the enable_ctrl button-to-enable path.
package enable_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button, debounces it and flags each debounced press.
module button_debouncer
  import enable_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_stable,
  output logic press_pulse
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          btn_stable_q, btn_stable_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = btn_in;
    sync2_d      = sync1_q;
    stable_d     = btn_stable_q;
    btn_stable_d = btn_stable_q;
    cnt_d        = cnt_q;
    if (sync2_q == btn_stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Disagreement lasted long enough: accept the new level.
      btn_stable_d = ~btn_stable_q;
      cnt_d        = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_stable_q <= 1'b0;
      stable_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_stable_q <= btn_stable_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
    end
  end

  assign btn_stable  = btn_stable_q;
  assign press_pulse = btn_stable_q & ~stable_q;

endmodule

// File: rtl/enable_ctrl.sv
// Button to counter-enable control: debounce, hold/toggle run FSM, prescaler.
module enable_ctrl
  import enable_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic mode,
  output logic enable,
  output logic running,
  output logic press_pulse
);

  localparam int PW = cnt_w(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic          btn_stable;
  state_e        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_stable (btn_stable),
    .press_pulse(press_pulse)
  );

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = '0;
    if (!mode) begin
      state_d = btn_stable ? RUN : IDLE;
    end else if (press_pulse) begin
      state_d = (state_q == RUN) ? IDLE : RUN;
    end
    // Count only while staying in RUN so every entry starts from zero.
    if (state_q == RUN && state_d == RUN) begin
      pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign running = (state_q == RUN);
  assign enable  = (state_q == RUN) && (pre_cnt_q == PRE_LAST);

endmodule

// File: tb/tb_enable_ctrl.sv
// Self-checking bench for enable_ctrl at PRESCALE=1 and PRESCALE=4.
module tb_enable_ctrl;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic mode = 1'b0;
  logic en1, run1, pp1;
  logic en4, run4, pp4;
  logic [3:0] dcnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pp = 0, n_en = 0, n_en4 = 0;

  // Reference model state
  bit m_s1, m_s2, m_stable, m_prev, m_run;
  int m_rc;
  bit hist[$];

  always #5 clk = ~clk;

  enable_ctrl #(.DEBOUNCE_CYCLES(DEB), .PRESCALE(1)) dut_p1 (
    .clk(clk), .reset(rst), .btn_in(btn), .mode(mode),
    .enable(en1), .running(run1), .press_pulse(pp1)
  );

  enable_ctrl #(.DEBOUNCE_CYCLES(DEB), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset(rst), .btn_in(btn), .mode(mode),
    .enable(en4), .running(run4), .press_pulse(pp4)
  );

  // Downstream 4-bit counter
  always_ff @(posedge clk) begin
    if (rst) dcnt <= '0;
    else if (en1) dcnt <= dcnt + 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Button level becomes stable once DEB consecutive synchronized samples
  // disagree with it; run state follows hold/toggle rules.
  task automatic model_edge(input bit r, input bit b, input bit md);
    bit pulse, nrun, nstable, all_diff;
    pulse = m_stable & ~m_prev;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_prev = 0; m_run = 0; m_rc = 0;
      hist.delete();
    end else begin
      nrun = md ? (pulse ? ~m_run : m_run) : m_stable;
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      nstable = m_stable;
      if (hist.size() == DEB) begin
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
        if (all_diff) nstable = ~m_stable;
      end
      m_rc = nrun ? (m_run ? m_rc + 1 : 1) : 0;
      m_prev = m_stable;
      m_stable = nstable;
      m_run = nrun;
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic cycle(input bit r, input bit b, input bit md);
    rst = r; btn = b; mode = md;
    model_edge(r, b, md);
    @(posedge clk); #1;
    chk("running_p1", int'(run1), int'(m_run));
    chk("pulse_p1", int'(pp1), int'(m_stable & ~m_prev));
    chk("enable_p1", int'(en1), int'(m_run));
    chk("running_p4", int'(run4), int'(m_run));
    chk("pulse_p4", int'(pp4), int'(m_stable & ~m_prev));
    chk("enable_p4", int'(en4), int'(m_run && (m_rc % 4 == 0)));
    if (pp1) n_pp++;
    if (en1) n_en++;
    if (en4) n_en4++;
  endtask

  typedef struct {
    bit r, b, md;
    bit en, run, pp;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int first_en, last_en, idx, bounce_pp, lvl_len;
    bit lvl, md;

    // Reset with button held, then toggle-mode press latency.
    foreach (tbl[i]) begin
      tbl[i] = '{r: (i < 2), b: 1, md: 1,
                 en: (i >= 8), run: (i >= 8), pp: (i == 7)};
    end
    n_pp = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].b, tbl[i].md);
      chk("tbl_enable", int'(en1), int'(tbl[i].en));
      chk("tbl_running", int'(run1), int'(tbl[i].run));
      chk("tbl_pulse", int'(pp1), int'(tbl[i].pp));
    end

    // Toggle mode: release keeps RUN, second press stops.
    for (int i = 0; i < 12; i++) cycle(0, 0, 1);
    chk("toggle_release_keeps_run", int'(run1), 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1);
    chk("toggle_second_press_stops", int'(run1), 0);
    chk("toggle_pulse_count", n_pp, 2);

    // Hold mode: 20 cycles pressed.
    cycle(1, 0, 0); cycle(1, 0, 0);
    n_en = 0; n_en4 = 0; first_en = -1; last_en = -1;
    for (int i = 1; i <= 32; i++) begin
      cycle(0, (i <= 20), 0);
      if (en1) begin
        if (first_en < 0) first_en = i;
        last_en = i;
      end
    end
    chk("hold_first_enable_edge", first_en, DEB + 3);
    chk("hold_last_enable_edge", last_en, 20 + DEB + 2);
    chk("hold_enable_cycles", n_en, 20);
    chk("hold_counter_value", int'(dcnt), 20 % 16);
    chk("hold_p4_strobes", n_en4, 5);

    // Bounce rejection then a steady press.
    cycle(1, 0, 1); cycle(1, 0, 1);
    n_pp = 0;
    for (int i = 0; i < 12; i++) cycle(0, ((i / 2) % 2 == 0), 1);
    bounce_pp = n_pp;
    chk("bounce_no_pulse", bounce_pp, 0);
    idx = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 1, 1);
      if (pp1 && idx < 0) idx = i;
    end
    chk("bounce_pulse_edge", idx, DEB + 2);
    chk("bounce_pulse_count", n_pp, 1);

    // Mode 1->0 in RUN with button released.
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    chk("modesw_pre_run", int'(run1), 1);
    cycle(0, 0, 0);
    chk("modesw_running", int'(run1), 0);
    chk("modesw_enable", int'(en1), 0);

    // Reset mid-RUN.
    for (int i = 0; i < 10; i++) cycle(0, 1, 1);
    chk("midrst_pre_enable", int'(en1), 1);
    cycle(1, 1, 1);
    chk("midrst_enable", int'(en1), 0);
    chk("midrst_running", int'(run1), 0);

    // Randomized traffic against the model.
    lvl = 0; md = 0;
    for (int n = 0; n < 3000; n += lvl_len) begin
      lvl = ~lvl;
      lvl_len = $urandom_range(1, 12);
      if ($urandom_range(0, 15) == 0) md = ~md;
      for (int k = 0; k < lvl_len; k++)
        cycle(($urandom_range(0, 199) == 0), lvl, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
